// File: rtl/cfg_pkg.sv
// Shared types for the I2C command arbiter: byte command struct, FSM states, byte width.
package cfg_pkg;
  localparam int DATA_WIDTH = 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] din;
    logic                  start;
    logic                  stop;
    logic                  read;
    logic                  write;
    logic                  ack_in;
  } i2c_cmd_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, RESP, HOLD} arb_state_t;

  // read+write together, or no read/write/stop at all, is not a byte command
  function automatic logic cmd_bad(input i2c_cmd_t c);
    return (c.read & c.write) | ~(c.read | c.write | c.stop);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx
);
  localparam int PW = $clog2(N_REQ);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    // scan farthest offset first so the nearest one to ptr wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end
endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin owner of one i2c byte-ctrl command port; lock held from first command until STOP.
// Optional WAIT_ACK watchdog with controller reset: define I2C_ARB_TIMEOUT_EN.
module i2c_cmd_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_WIDTH  = cfg_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  cfg_pkg::i2c_cmd_t [N_REQ-1:0] req_cmd_i,
  output logic [N_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]       rsp_dout_o,
  output logic                        rsp_ack_o,
  output logic                        rsp_err_o,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        ctl_start_o,
  output logic                        ctl_stop_o,
  output logic                        ctl_read_o,
  output logic                        ctl_write_o,
  output logic                        ctl_ack_in_o,
  output logic [DATA_WIDTH-1:0]       ctl_din_o,
  output logic                        ctl_rst_o,
  input  logic                        ctl_cmd_ack_i,
  input  logic                        ctl_ack_out_i,
  input  logic [DATA_WIDTH-1:0]       ctl_dout_i,
  input  logic                        ctl_al_i
);
  import cfg_pkg::*;
  localparam int PW = $clog2(N_REQ);

  arb_state_t       state;
  logic [PW-1:0]    ptr, owner, pick_idx, acc_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             stop_q, release_q, acc, tmo;
  i2c_cmd_t         acc_cmd;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req (req_valid_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    req_ready_o = '0;
    if (state == IDLE)      req_ready_o = pick_gnt;
    else if (state == HOLD) req_ready_o = grant_o & req_valid_i;
  end

  assign acc     = |req_ready_o;
  assign acc_idx = (state == IDLE) ? pick_idx : owner;
  assign acc_cmd = req_cmd_i[acc_idx];

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tcnt;

  assign tmo = (state == WAIT_ACK) && (tcnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || state != WAIT_ACK) tcnt <= '0;
    else                            tcnt <= tcnt + 1'b1;
    // abort only when neither al nor cmd_ack completes the command this cycle
    if (rst_i) ctl_rst_o <= 1'b0;
    else       ctl_rst_o <= tmo & ~ctl_al_i & ~ctl_cmd_ack_i;
  end
`else
  assign tmo       = 1'b0;
  assign ctl_rst_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      stop_q       <= 1'b0;
      release_q    <= 1'b0;
      grant_o      <= '0;
      rsp_valid_o  <= '0;
      rsp_dout_o   <= '0;
      rsp_ack_o    <= 1'b0;
      rsp_err_o    <= 1'b0;
      ctl_start_o  <= 1'b0;
      ctl_stop_o   <= 1'b0;
      ctl_read_o   <= 1'b0;
      ctl_write_o  <= 1'b0;
      ctl_ack_in_o <= 1'b0;
      ctl_din_o    <= '0;
    end else begin
      rsp_valid_o  <= '0;
      rsp_err_o    <= 1'b0;
      ctl_start_o  <= 1'b0;
      ctl_stop_o   <= 1'b0;
      ctl_read_o   <= 1'b0;
      ctl_write_o  <= 1'b0;
      ctl_ack_in_o <= 1'b0;
      ctl_din_o    <= '0;
      case (state)
        IDLE, HOLD: if (acc) begin
          owner <= acc_idx;
          if (state == IDLE) grant_o <= pick_gnt;
          if (cmd_bad(acc_cmd)) begin
            // rejected command keeps the lock; owner must still close with STOP
            rsp_valid_o <= req_ready_o;
            rsp_err_o   <= 1'b1;
            release_q   <= 1'b0;
            state       <= RESP;
          end else begin
            stop_q       <= acc_cmd.stop;
            ctl_start_o  <= acc_cmd.start;
            ctl_stop_o   <= acc_cmd.stop;
            ctl_read_o   <= acc_cmd.read;
            ctl_write_o  <= acc_cmd.write;
            ctl_ack_in_o <= acc_cmd.ack_in;
            ctl_din_o    <= acc_cmd.din;
            state        <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_ACK;
        WAIT_ACK: if (ctl_al_i || ctl_cmd_ack_i || tmo) begin
          rsp_valid_o <= N_REQ'(1) << owner;
          if (ctl_al_i || !ctl_cmd_ack_i) begin
            rsp_err_o <= 1'b1;
            release_q <= 1'b1;
            grant_o   <= '0;
          end else begin
            rsp_dout_o <= ctl_dout_i;
            rsp_ack_o  <= ctl_ack_out_i;
            release_q  <= stop_q;
            if (stop_q) grant_o <= '0;
          end
          state <= RESP;
        end
        RESP: begin
          if (release_q) begin
            ptr   <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter; timeout case runs when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_cmd_arbiter;
  import cfg_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  i2c_cmd_t [N-1:0] req_cmd;
  logic [N-1:0]   rsp_valid, grant;
  logic [7:0]     rsp_dout, ctl_din, ctl_dout;
  logic           rsp_ack, rsp_err;
  logic           ctl_start, ctl_stop, ctl_read, ctl_write, ctl_ack_in, ctl_rst;
  logic           ctl_cmd_ack, ctl_ack_out, ctl_al;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2c_cmd_arbiter #(.N_REQ(N), .DATA_WIDTH(8), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(req_cmd),
    .rsp_valid_o(rsp_valid), .rsp_dout_o(rsp_dout), .rsp_ack_o(rsp_ack), .rsp_err_o(rsp_err),
    .grant_o(grant),
    .ctl_start_o(ctl_start), .ctl_stop_o(ctl_stop), .ctl_read_o(ctl_read),
    .ctl_write_o(ctl_write), .ctl_ack_in_o(ctl_ack_in), .ctl_din_o(ctl_din),
    .ctl_rst_o(ctl_rst), .ctl_cmd_ack_i(ctl_cmd_ack), .ctl_ack_out_i(ctl_ack_out),
    .ctl_dout_i(ctl_dout), .ctl_al_i(ctl_al)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic i2c_cmd_t mk(input logic [7:0] din, input logic start, stop, read, write, ack_in);
    i2c_cmd_t c;
    c.din = din; c.start = start; c.stop = stop; c.read = read; c.write = write; c.ack_in = ack_in;
    return c;
  endfunction

  // drive one controller completion cycle from WAIT_ACK; returns in RESP
  task automatic complete(input logic [7:0] dout, input logic ack_out, input logic al);
    ctl_cmd_ack = 1'b1; ctl_dout = dout; ctl_ack_out = ack_out; ctl_al = al;
    tick;
    ctl_cmd_ack = 1'b0; ctl_al = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask

  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};
    int n;
    req_valid = '0; req_cmd = '0;
    ctl_cmd_ack = 1'b0; ctl_ack_out = 1'b0; ctl_dout = '0; ctl_al = 1'b0;
    do_reset;

    chk("rst_grant", grant, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ctl", {ctl_start, ctl_stop, ctl_read, ctl_write, ctl_ack_in, ctl_rst}, 0);
    chk("rst_ready", req_ready, 0);

    // 1: write 0xD0 with start, no stop
    req_cmd[0] = mk(8'hD0, 1, 0, 0, 1, 0);
    req_valid  = 4'b0001;
    #1 chk("t1_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    chk("t1_pulse", {ctl_start, ctl_write, ctl_read, ctl_stop}, 4'b1100);
    chk("t1_din", ctl_din, 8'hD0);
    chk("t1_grant", grant, 4'b0001);
    tick;
    chk("t1_pulse_gone", {ctl_start, ctl_write, ctl_din}, 0);
    complete(8'h00, 1'b0, 1'b0);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_grant_held", grant, 4'b0001);
    tick;

    // 2: req1 blocked while req0 holds the lock
    req_cmd[1] = mk(8'h11, 1, 1, 0, 1, 0);
    req_valid  = 4'b0010;
    #1 chk("t2_blocked0", req_ready, 0);
    tick; tick;
    chk("t2_blocked1", req_ready, 0);
    req_cmd[0] = mk(8'h00, 0, 1, 0, 0, 0);
    req_valid  = 4'b0011;
    #1 chk("t2_owner_ready", req_ready, 4'b0001);
    tick;
    req_valid = 4'b0010;
    chk("t2_stop_pulse", ctl_stop, 1);
    tick;
    chk("t2_wait_ready", req_ready, 0);
    complete(8'h00, 1'b0, 1'b0);
    chk("t2_release", grant, 0);
    tick;
    chk("t2_req1_ready", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    chk("t2_grant1", grant, 4'b0010);
    tick;
    complete(8'h00, 1'b0, 1'b0);
    tick;

    // 3: all requesting, stop commands rotate 0,1,2,3,0
    do_reset;
    for (int i = 0; i < N; i++) req_cmd[i] = mk(8'h40 + 8'(i), 1, 1, 0, 1, 0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t3_ready%0d", k), req_ready, 32'(1) << seq[k]);
      tick;
      chk($sformatf("t3_grant%0d", k), grant, 32'(1) << seq[k]);
      tick;
      complete(8'h00, 1'b0, 1'b0);
      chk($sformatf("t3_rsp%0d", k), rsp_valid, 32'(1) << seq[k]);
      tick;
    end
    req_valid = '0;

    // 4: read with stop on req2; pointer now 1
    req_cmd[2] = mk(8'h00, 0, 1, 1, 0, 1);
    req_valid  = 4'b0100;
    #1 chk("t4_ready", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    chk("t4_pulse", {ctl_read, ctl_stop, ctl_ack_in, ctl_write}, 4'b1110);
    tick;
    complete(8'hA5, 1'b1, 1'b0);
    chk("t4_dout", rsp_dout, 8'hA5);
    chk("t4_ack", rsp_ack, 1);
    chk("t4_err", rsp_err, 0);
    chk("t4_valid", rsp_valid, 4'b0100);
    tick;

    // 5: arbitration lost together with cmd_ack on req3
    req_cmd[3] = mk(8'h42, 1, 0, 0, 1, 0);
    req_valid  = 4'b1000;
    #1 chk("t5_ready", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    tick;
    complete(8'h00, 1'b0, 1'b1);
    chk("t5_err", rsp_err, 1);
    chk("t5_valid", rsp_valid, 4'b1000);
    chk("t5_grant", grant, 0);
    tick;

    // illegal read+write: answered next cycle with err, lock kept, no pulse
    req_cmd[0] = mk(8'h00, 0, 0, 1, 1, 0);
    req_valid  = 4'b0001;
    #1 chk("ill_ready", req_ready, 4'b0001);
    tick;
    chk("ill_rsp", {rsp_valid, rsp_err}, 5'b00011);
    chk("ill_no_pulse", {ctl_read, ctl_write, ctl_stop}, 0);
    chk("ill_lock", grant, 4'b0001);
    tick;
    req_cmd[0] = mk(8'h00, 0, 1, 0, 0, 0);
    req_valid  = 4'b0011;
    #1 chk("ill_hold_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    tick;
    complete(8'h00, 1'b0, 1'b0);
    chk("ill_release", grant, 0);
    tick;

`ifdef I2C_ARB_TIMEOUT_EN
    // 6: no cmd_ack -> controller reset after 16 WAIT_ACK cycles
    req_cmd[1] = mk(8'h55, 1, 0, 0, 1, 0);
    req_valid  = 4'b0010;
    tick;
    req_valid = '0;
    tick;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (ctl_rst) begin n = i; break; end
    end
    chk("t6_tmo_cycle", n, 16);
    chk("t6_tmo_err", {rsp_valid, rsp_err}, 5'b00101);
    chk("t6_tmo_grant", grant, 0);
    tick;
    chk("t6_rst_pulse_1cyc", ctl_rst, 0);
`endif

    // reset in the middle of WAIT_ACK
    req_cmd[2] = mk(8'h77, 1, 0, 0, 1, 0);
    req_valid  = 4'b0100;
    tick;
    req_valid = '0;
    chk("rw_grant_taken", grant, 4'b0100);
    tick; tick; tick;
    rst = 1'b1;
    tick;
    chk("rw_outputs", {grant, rsp_valid, rsp_err, ctl_write, ctl_start, ctl_rst, ctl_din}, 0);
    rst = 1'b0;
    req_valid = 4'b0001;
    #1 chk("rw_ptr0", req_ready, 4'b0001);
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
